bram_port_arb: RTL and testbench

BRAM_PORT_ARB -- requirements
Module: bram_port_arb

---
 rtl/bram_arb_pkg.sv | 13 +
 rtl/bram_rr_arb.sv | 26 ++
 rtl/bram_port_arb.sv | 137 +++++++++++++
 tb/tb_bram_port_arb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester BRAM port arbiter.
package bram_arb_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t BURST = 1'b1;

    localparam logic [31:0] ADDR_STEP = 32'd4;
    localparam int          LEN_W     = 4;
    localparam int          MAX_BURST = 16;

endpackage

// File: rtl/bram_rr_arb.sv
// Two-way round-robin picker; the pointer moves past whoever was granted on advance.
module bram_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // prio=0: requester 0 wins a tie, prio=1: requester 1 wins
    logic prio;

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = prio ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'b0;
        else if (advance && (grant != 2'b00))
            prio <= grant[0];
    end

endmodule

// File: rtl/bram_port_arb.sv
// Burst arbiter sharing one BRAM port between two requesters, with read-data routing.
module bram_port_arb
    import bram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_we,
    input  logic [31:0]      req0_addr,
    input  logic [LEN_W-1:0] req0_len,
    input  logic [31:0]      req0_wdata,
    output logic             req0_gnt,
    output logic             req0_beat,
    output logic             req0_rvalid,
    output logic [31:0]      req0_rdata,
    input  logic             req1_valid,
    input  logic [3:0]       req1_we,
    input  logic [31:0]      req1_addr,
    input  logic [LEN_W-1:0] req1_len,
    input  logic [31:0]      req1_wdata,
    output logic             req1_gnt,
    output logic             req1_beat,
    output logic             req1_rvalid,
    output logic [31:0]      req1_rdata,
    output logic             ram_clk,
    output logic             ram_rst,
    output logic             ram_en,
    output logic [3:0]       ram_we,
    output logic [31:0]      ram_addr,
    output logic [31:0]      ram_wr_data,
    input  logic [31:0]      ram_rd_data
);

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic             owner;
    logic [3:0]       cap_we;
    logic [1:0]       grant;
    logic             idle;
    logic             sel;
    logic [3:0]       sel_we;
    logic [31:0]      sel_addr;
    logic [LEN_W-1:0] sel_len;
    logic             beat_owner;
    logic             beat_act;
    logic [31:0]      beat_wdata;
    logic             rd_issue;
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] own_pipe;

    assign idle = (state == IDLE);

    bram_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .advance (idle),
        .grant   (grant)
    );

    assign sel      = grant[1];
    assign sel_we   = sel ? req1_we   : req0_we;
    assign sel_addr = (sel ? req1_addr : req0_addr) & ~32'h3;
    assign sel_len  = sel ? req1_len  : req0_len;

    // The first beat is issued in the grant cycle itself, the rest from BURST.
    assign beat_owner = idle ? sel : owner;
    assign beat_act   = !rst && (idle ? (grant != 2'b00) : (cnt != '0));
    assign beat_wdata = beat_owner ? req1_wdata : req0_wdata;

    assign req0_gnt  = !rst && idle && grant[0];
    assign req1_gnt  = !rst && idle && grant[1];
    assign req0_beat = beat_act && !beat_owner;
    assign req1_beat = beat_act &&  beat_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= 1'b0;
            cap_we      <= 4'h0;
            ram_en      <= 1'b0;
            ram_we      <= 4'h0;
            ram_addr    <= 32'h0;
            ram_wr_data <= 32'h0;
        end else if (idle) begin
            if (grant != 2'b00) begin
                state       <= BURST;
                owner       <= sel;
                cap_we      <= sel_we;
                cnt         <= sel_len;
                ram_en      <= 1'b1;
                ram_we      <= sel_we;
                ram_addr    <= sel_addr;
                ram_wr_data <= beat_wdata;
            end else begin
                ram_en <= 1'b0;
                ram_we <= 4'h0;
            end
        end else if (cnt != '0) begin
            cnt         <= cnt - 1'b1;
            ram_en      <= 1'b1;
            ram_we      <= cap_we;
            ram_addr    <= ram_addr + ADDR_STEP;
            ram_wr_data <= beat_wdata;
        end else begin
            // Last beat is on the port now; this cycle leaves the mandatory idle gap.
            state  <= IDLE;
            ram_en <= 1'b0;
            ram_we <= 4'h0;
        end
    end

    // owner stays valid through the final ram_en cycle, so it tags reads directly.
    assign rd_issue = ram_en && (ram_we == 4'h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe <= RD_LAT'({vld_pipe, rd_issue});
            own_pipe <= RD_LAT'({own_pipe, owner});
        end
    end

    assign req0_rvalid = !rst && vld_pipe[RD_LAT-1] && !own_pipe[RD_LAT-1];
    assign req1_rvalid = !rst && vld_pipe[RD_LAT-1] &&  own_pipe[RD_LAT-1];
    assign req0_rdata  = ram_rd_data;
    assign req1_rdata  = ram_rd_data;

    assign ram_clk = clk;
    assign ram_rst = 1'b0;

endmodule

// File: tb/tb_bram_port_arb.sv
// Directed bench: one instance at RD_LAT=1 and one at RD_LAT=3 share the same stimulus.
module tb_bram_port_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic [3:0]  r0_we = 4'h0, r1_we = 4'h0;
    logic [31:0] r0_addr = 32'h0, r1_addr = 32'h0;
    logic [3:0]  r0_len = 4'h0, r1_len = 4'h0;
    logic [31:0] r0_wdata = 32'h0, r1_wdata = 32'h0;
    logic [31:0] rd_data = 32'h0;

    logic        a_gnt0, a_gnt1, a_beat0, a_beat1, a_rvalid0, a_rvalid1;
    logic [31:0] a_rdata0, a_rdata1, a_ram_addr, a_ram_wr_data;
    logic        a_ram_clk, a_ram_rst, a_ram_en;
    logic [3:0]  a_ram_we;
    logic        b_gnt0, b_gnt1, b_beat0, b_beat1, b_rvalid0, b_rvalid1;
    logic [31:0] b_rdata0, b_rdata1, b_ram_addr, b_ram_wr_data;
    logic        b_ram_clk, b_ram_rst, b_ram_en;
    logic [3:0]  b_ram_we;

    int checks = 0;
    int errors = 0;

    logic [31:0] wrap_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    always #5 clk = ~clk;

    bram_port_arb #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(r0_valid), .req0_we(r0_we), .req0_addr(r0_addr), .req0_len(r0_len),
        .req0_wdata(r0_wdata), .req0_gnt(a_gnt0), .req0_beat(a_beat0),
        .req0_rvalid(a_rvalid0), .req0_rdata(a_rdata0),
        .req1_valid(r1_valid), .req1_we(r1_we), .req1_addr(r1_addr), .req1_len(r1_len),
        .req1_wdata(r1_wdata), .req1_gnt(a_gnt1), .req1_beat(a_beat1),
        .req1_rvalid(a_rvalid1), .req1_rdata(a_rdata1),
        .ram_clk(a_ram_clk), .ram_rst(a_ram_rst), .ram_en(a_ram_en), .ram_we(a_ram_we),
        .ram_addr(a_ram_addr), .ram_wr_data(a_ram_wr_data), .ram_rd_data(rd_data)
    );

    bram_port_arb #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(r0_valid), .req0_we(r0_we), .req0_addr(r0_addr), .req0_len(r0_len),
        .req0_wdata(r0_wdata), .req0_gnt(b_gnt0), .req0_beat(b_beat0),
        .req0_rvalid(b_rvalid0), .req0_rdata(b_rdata0),
        .req1_valid(r1_valid), .req1_we(r1_we), .req1_addr(r1_addr), .req1_len(r1_len),
        .req1_wdata(r1_wdata), .req1_gnt(b_gnt1), .req1_beat(b_beat1),
        .req1_rvalid(b_rvalid1), .req1_rdata(b_rdata1),
        .ram_clk(b_ram_clk), .ram_rst(b_ram_rst), .ram_en(b_ram_en), .ram_we(b_ram_we),
        .ram_addr(b_ram_addr), .ram_wr_data(b_ram_wr_data), .ram_rd_data(rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        // Reset state; a pending request must not be granted while rst is high.
        r0_valid = 1'b1;
        cyc();
        cyc();
        smp();
        chk("rst_en", a_ram_en, 0);
        chk("rst_we", a_ram_we, 0);
        chk("rst_addr", a_ram_addr, 0);
        chk("rst_wdata", a_ram_wr_data, 0);
        chk("rst_gnt", {a_gnt1, a_gnt0}, 0);
        chk("rst_beat", {a_beat1, a_beat0}, 0);
        chk("rst_rvalid", {b_rvalid1, b_rvalid0, a_rvalid1, a_rvalid0}, 0);
        chk("ram_rst", a_ram_rst, 0);
        cyc();
        rst = 1'b0;

        // 4-beat read from requester 0 at 0x10.
        r0_valid = 1'b1; r0_we = 4'h0; r0_addr = 32'h10; r0_len = 4'd3;
        for (int c = 0; c <= 6; c++) begin
            rd_data = 32'hA000_0000 + c;
            smp();
            chk($sformatf("t1_gnt0_c%0d", c), a_gnt0, c == 0);
            chk($sformatf("t1_beat0_c%0d", c), a_beat0, c <= 3);
            chk($sformatf("t1_en_c%0d", c), a_ram_en, c >= 1 && c <= 4);
            if (c >= 1 && c <= 4)
                chk($sformatf("t1_addr_c%0d", c), a_ram_addr, 32'h10 + 4 * (c - 1));
            chk($sformatf("t1_rv0_c%0d", c), a_rvalid0, c >= 2 && c <= 5);
            if (c >= 2 && c <= 5)
                chk($sformatf("t1_rd0_c%0d", c), a_rdata0, 32'hA000_0000 + c);
            chk($sformatf("t1_rv1_c%0d", c), a_rvalid1, 0);
            cyc();
            r0_valid = 1'b0;
        end

        // Both held valid with 1-beat writes: grants alternate 0,1,0,1 with idle gaps.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        r0_valid = 1'b1; r0_we = 4'hF; r0_addr = 32'h100; r0_len = 4'd0; r0_wdata = 32'h1111_0000;
        r1_valid = 1'b1; r1_we = 4'hF; r1_addr = 32'h200; r1_len = 4'd0; r1_wdata = 32'h2222_0000;
        for (int c = 0; c <= 7; c++) begin
            smp();
            chk($sformatf("t2_gnt0_c%0d", c), a_gnt0, c % 4 == 0);
            chk($sformatf("t2_gnt1_c%0d", c), a_gnt1, c % 4 == 2);
            chk($sformatf("t2_beat_c%0d", c), {a_beat1, a_beat0}, {a_gnt1 === 1'b1, a_gnt0 === 1'b1});
            chk($sformatf("t2_en_c%0d", c), a_ram_en, c % 2 == 1);
            if (c % 2 == 1) begin
                chk($sformatf("t2_addr_c%0d", c), a_ram_addr, (c % 4 == 1) ? 32'h100 : 32'h200);
                chk($sformatf("t2_wd_c%0d", c), a_ram_wr_data,
                    (c % 4 == 1) ? 32'h1111_0000 : 32'h2222_0000);
                chk($sformatf("t2_we_c%0d", c), a_ram_we, 4'hF);
            end
            cyc();
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        // Requester 1 write burst wrapping past the top of the address space.
        r1_valid = 1'b1; r1_we = 4'hF; r1_addr = 32'hFFFF_FFF8; r1_len = 4'd3;
        for (int c = 0; c <= 5; c++) begin
            r1_wdata = 32'hD0 + c;
            smp();
            chk($sformatf("t3_gnt1_c%0d", c), a_gnt1, c == 0);
            chk($sformatf("t3_beat1_c%0d", c), a_beat1, c <= 3);
            chk($sformatf("t3_en_c%0d", c), a_ram_en, c >= 1 && c <= 4);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("t3_addr_c%0d", c), a_ram_addr, wrap_exp[c - 1]);
                chk($sformatf("t3_wd_c%0d", c), a_ram_wr_data, 32'hD0 + c - 1);
                chk($sformatf("t3_we_c%0d", c), a_ram_we, 4'hF);
            end
            chk($sformatf("t3_rv1_c%0d", c), a_rvalid1, 0);
            cyc();
            r1_valid = 1'b0;
            r1_addr  = 32'h0;
            r1_len   = 4'd0;
        end

        // Unaligned start address is forced to a word boundary.
        r0_valid = 1'b1; r0_we = 4'hF; r0_addr = 32'h13; r0_len = 4'd0;
        smp();
        chk("t4_gnt0", a_gnt0, 1);
        cyc();
        r0_valid = 1'b0;
        smp();
        chk("t4_en", a_ram_en, 1);
        chk("t4_addr", a_ram_addr, 32'h10);
        chk("t4_we", a_ram_we, 4'hF);
        cyc();
        smp();
        chk("t4_en_off", a_ram_en, 0);
        chk("t4_we_off", a_ram_we, 0);
        cyc();

        // Back-to-back 1-beat reads: req0 data still in flight when req1 is granted.
        r0_valid = 1'b1; r0_we = 4'h0; r0_addr = 32'h40; r0_len = 4'd0;
        r1_we = 4'h0; r1_addr = 32'h80; r1_len = 4'd0;
        for (int c = 0; c <= 7; c++) begin
            if (c == 1) begin
                r0_valid = 1'b0;
                r1_valid = 1'b1;
            end
            if (c == 3)
                r1_valid = 1'b0;
            rd_data = 32'hB000_0000 + c;
            smp();
            chk($sformatf("t5_gnt0_c%0d", c), a_gnt0, c == 0);
            chk($sformatf("t5_gnt1_c%0d", c), a_gnt1, c == 2);
            chk($sformatf("t5_a_rv0_c%0d", c), a_rvalid0, c == 2);
            chk($sformatf("t5_a_rv1_c%0d", c), a_rvalid1, c == 4);
            chk($sformatf("t5_b_rv0_c%0d", c), b_rvalid0, c == 4);
            chk($sformatf("t5_b_rv1_c%0d", c), b_rvalid1, c == 6);
            if (c == 6)
                chk("t5_b_rd1", b_rdata1, 32'hB000_0006);
            cyc();
        end

        // Reset during a 16-beat read aborts it and restores requester 0 priority.
        r0_valid = 1'b1; r0_we = 4'h0; r0_addr = 32'h200; r0_len = 4'd15;
        smp();
        chk("t6_gnt0", a_gnt0, 1);
        cyc();
        r0_valid = 1'b0;
        smp();
        chk("t6_addr_b0", a_ram_addr, 32'h200);
        cyc();
        smp();
        chk("t6_addr_b1", a_ram_addr, 32'h204);
        chk("t6_rv0_pre", a_rvalid0, 1);
        cyc();
        rst = 1'b1;
        smp();
        chk("t6_addr_b2", a_ram_addr, 32'h208);
        chk("t6_rv0_in_rst", a_rvalid0, 0);
        chk("t6_beat0_in_rst", a_beat0, 0);
        cyc();
        rst = 1'b0;
        smp();
        chk("t6_en_abort", a_ram_en, 0);
        chk("t6_a_rv0_abort", a_rvalid0, 0);
        chk("t6_b_rv0_abort", b_rvalid0, 0);
        cyc();
        r0_valid = 1'b1; r0_len = 4'd0;
        r1_valid = 1'b1;
        smp();
        chk("t6_gnt0_after", a_gnt0, 1);
        chk("t6_gnt1_after", a_gnt1, 0);
        chk("t6_b_rv0_late", b_rvalid0, 0);
        cyc();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        smp();
        chk("t6_b_rv0_tail", b_rvalid0, 0);
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
